rom_loader: RTL

Boot-time program loader that is the reading end of the generated program ROM interface: 32-bit byte address out, 8-bit byte and `done` flag in.
- Walks the ROM from byte address 0 until the ROM flags `done`.
- Packs bytes little-endian into 32-bit instruction words and writes each word into instruction memory through a ready/enable handshake.
- Holds the core in reset via `busy` until the image is fully loaded.

---
 rtl/rom_loader_pkg.sv | 24 ++
 rtl/rom_loader_word_packer.sv | 58 +++++
 rtl/rom_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// rom_loader_pkg
// Shared definitions for the boot-time program loader: the loader FSM state
// encoding, the byte-lane index type used while packing ROM bytes into
// instruction words, and the word geometry constants.
// -----------------------------------------------------------------------------
package rom_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_WIDTH     = 32;

   // Index of the byte lane currently being filled (lane 0 = bits 7:0).
   typedef logic [$clog2(BYTES_PER_WORD)-1:0] lane_t;

   localparam lane_t LAST_LANE = lane_t'(BYTES_PER_WORD - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage : rom_loader_pkg

// File: rtl/rom_loader_word_packer.sv
// -----------------------------------------------------------------------------
// rom_loader_word_packer
// Little-endian byte-to-word assembler. Each push drops byte_i into the lane
// selected by the internal lane counter and advances it; clear empties the
// buffer and rewinds the lane to 0. Because the buffer is cleared between
// words, a word flushed before all lanes are filled carries zeros in the
// unfilled upper lanes.
//
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   clear_i     empty buffer and rewind lane (has priority over push_i)
//   push_i      store byte_i into the current lane and advance
//   byte_i      byte to store
//   lane_o      lane that the next push will fill
//   word_o      assembled word
// -----------------------------------------------------------------------------
module rom_loader_word_packer
   import rom_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic [7:0]            byte_i,
   output logic [1:0]            lane_o,
   output logic [WORD_WIDTH-1:0] word_o
);

   lane_t                 lane_q, lane_d;
   logic [WORD_WIDTH-1:0] word_q, word_d;

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (clear_i) begin
         lane_d = '0;
         word_d = '0;
      end else if (push_i) begin
         // {lane,3'b000} is lane*8: the bit offset of the lane's byte.
         word_d[{lane_q, 3'b000} +: 8] = byte_i;
         lane_d                        = lane_q + lane_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q <= '0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

   assign lane_o = lane_q;
   assign word_o = word_q;

endmodule : rom_loader_word_packer

// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
// Boot-time program loader. Walks the program ROM one byte per cycle from
// byte address 0 until the ROM raises rom_done, packs the bytes little-endian
// into 32-bit words and writes each word to instruction memory through a
// mem_we/mem_ready handshake. busy holds the core in reset while loading.
//
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   start         one-cycle pulse starting a (re)load; ignored while busy
//   rom_address   registered ROM byte address
//   rom_byte      ROM data for rom_address (combinational)
//   rom_done      ROM end-of-image flag for rom_address (combinational)
//   mem_addr      instruction-memory word address
//   mem_wdata     word being written
//   mem_we        write request, held until mem_ready
//   mem_ready     memory accepts the write when high together with mem_we
//   busy          load in progress
//   loaded        image fully written
//   partial_word  image length was not a multiple of 4 bytes
//   overflow      image did not fit in MAX_WORDS words
//   word_count    words written by the current / last load
// -----------------------------------------------------------------------------
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int MAX_WORDS      = 1024,
   parameter int BASE_WORD_ADDR = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic [31:0]               rom_address,
   input  logic [7:0]                rom_byte,
   input  logic                      rom_done,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0]     mem_wdata,
   output logic                      mem_we,
   input  logic                      mem_ready,
   output logic                      busy,
   output logic                      loaded,
   output logic                      partial_word,
   output logic                      overflow,
   output logic [MEM_ADDR_WIDTH:0]   word_count
);

   localparam logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = MEM_ADDR_WIDTH'(BASE_WORD_ADDR);
   localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE  = MEM_ADDR_WIDTH'(1);
   localparam logic [MEM_ADDR_WIDTH:0]   CNT_ONE   = (MEM_ADDR_WIDTH + 1)'(1);
   localparam logic [MEM_ADDR_WIDTH:0]   MAX_CNT   = (MEM_ADDR_WIDTH + 1)'(MAX_WORDS);

   state_e                    state_q, state_d;
   logic [31:0]               rom_addr_q, rom_addr_d;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [MEM_ADDR_WIDTH:0]   count_q, count_d;
   logic                      partial_q, partial_d;
   logic                      overflow_q, overflow_d;
   // flush_q: the word in WRITE is the short final word; load ends after it.
   logic                      flush_q, flush_d;
   // limit_q: MAX_WORDS written; next FETCH only peeks at rom_done.
   logic                      limit_q, limit_d;

   logic                      pk_clear;
   logic                      pk_push;
   logic [1:0]                pk_lane;
   logic [WORD_WIDTH-1:0]     pk_word;

   rom_loader_word_packer u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (pk_clear),
      .push_i  (pk_push),
      .byte_i  (rom_byte),
      .lane_o  (pk_lane),
      .word_o  (pk_word)
   );

   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      mem_addr_d = mem_addr_q;
      count_d    = count_q;
      partial_d  = partial_q;
      overflow_d = overflow_q;
      flush_d    = flush_q;
      limit_d    = limit_q;
      pk_clear   = 1'b0;
      pk_push    = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // A start from DONE is a full reload, identical to one from IDLE.
            if (start) begin
               state_d    = ST_FETCH;
               rom_addr_d = '0;
               mem_addr_d = BASE_ADDR;
               count_d    = '0;
               partial_d  = 1'b0;
               overflow_d = 1'b0;
               flush_d    = 1'b0;
               limit_d    = 1'b0;
               pk_clear   = 1'b1;
            end
         end

         ST_FETCH: begin
            if (limit_q) begin
               // Capacity used up: any byte still present means the image
               // was truncated. Nothing is consumed in this cycle.
               overflow_d = ~rom_done;
               limit_d    = 1'b0;
               state_d    = ST_DONE;
            end else if (rom_done) begin
               // The byte at the done address is never consumed.
               if (pk_lane == 2'd0) begin
                  state_d = ST_DONE;
               end else begin
                  partial_d = 1'b1;
                  flush_d   = 1'b1;
                  state_d   = ST_WRITE;
               end
            end else begin
               pk_push    = 1'b1;
               rom_addr_d = rom_addr_q + 32'd1;
               if (pk_lane == LAST_LANE) begin
                  state_d = ST_WRITE;
               end
            end
         end

         ST_WRITE: begin
            if (mem_ready) begin
               mem_addr_d = mem_addr_q + ADDR_ONE;
               count_d    = count_q + CNT_ONE;
               pk_clear   = 1'b1;
               if (flush_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FETCH;
                  limit_d = ((count_q + CNT_ONE) == MAX_CNT);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rom_addr_q <= '0;
         mem_addr_q <= BASE_ADDR;
         count_q    <= '0;
         partial_q  <= 1'b0;
         overflow_q <= 1'b0;
         flush_q    <= 1'b0;
         limit_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         mem_addr_q <= mem_addr_d;
         count_q    <= count_d;
         partial_q  <= partial_d;
         overflow_q <= overflow_d;
         flush_q    <= flush_d;
         limit_q    <= limit_d;
      end
   end

   // Status decoded straight from the state register so that reset clears
   // them without waiting for a clock edge.
   assign busy         = (state_q == ST_FETCH) || (state_q == ST_WRITE);
   assign loaded       = (state_q == ST_DONE);
   assign mem_we       = (state_q == ST_WRITE);
   assign rom_address  = rom_addr_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = pk_word;
   assign word_count   = count_q;
   assign partial_word = partial_q;
   assign overflow     = overflow_q;

endmodule : rom_loader
